// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side bundle of the UART receiver (byte, handshake, status).
// master = receiver (drives byte/status, takes ack); slave = consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (1+ stop bits) serial receiver with oversampled bit timing and a
// single-entry holding register with valid/ack handshake.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each
// sample point instead of a single sample.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVS / 2);
  localparam logic [OS_W-1:0]  OS_START = OS_W'(OVS / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);

`ifdef UART_RX_MAJORITY_EN
  // Start decision waits for the third vote at centre+1.
  localparam logic [OS_W-1:0]  OS_START_DEC = OS_HALF;
`else
  localparam logic [OS_W-1:0]  OS_START_DEC = OS_START;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic             rx_s1, rx_s2, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t           state, state_d;
  logic [OS_W-1:0]  os_cnt, os_cnt_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shreg, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             commit;
  logic             start_bit, bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]       vote, vote_d;
  logic             bit_q, bit_q_d;
  logic             maj;
  logic [OS_W-1:0]  centre;
`endif

  assign rx_s = rx_s2;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Free-running oversample tick divider, independent of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

`ifdef UART_RX_MAJORITY_EN
  // Votes are taken at centre-1 and centre; the third comes live at centre+1.
  always_comb begin
    centre    = (state == ST_START) ? OS_START : OS_HALF;
    maj       = (vote[0] & vote[1]) | (rx_s & (vote[0] | vote[1]));
    start_bit = maj;
    bit_val   = bit_q;
    vote_d    = vote;
    bit_q_d   = bit_q;
    if (tick && (state != ST_IDLE)) begin
      if (os_cnt == centre - OS_ONE) vote_d[0] = rx_s;
      if (os_cnt == centre)          vote_d[1] = rx_s;
      if ((os_cnt == centre + OS_ONE) && (state != ST_START)) bit_q_d = maj;
    end
  end

  // Majority vote storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote  <= '1;
      bit_q <= 1'b1;
    end else begin
      vote  <= vote_d;
      bit_q <= bit_q_d;
    end
  end
`else
  // Single-sample build: the synced line is the bit value at the sample point.
  always_comb begin
    start_bit = rx_s;
    bit_val   = rx_s;
  end
`endif

  // Next-state, datapath and handshake/status update.
  always_comb begin
    state_d   = state;
    os_cnt_d  = os_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    commit    = 1'b0;

    if (bus.rx_ack) valid_d = 1'b0;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d  = ST_START;
            os_cnt_d = '0;
          end
        end
        ST_START: begin
          if (os_cnt == OS_START_DEC) begin
            if (start_bit) begin
              state_d = ST_IDLE;
            end else begin
              os_cnt_d  = '0;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end else begin
            os_cnt_d = os_cnt + OS_ONE;
          end
        end
        ST_DATA: begin
          if (os_cnt == OS_LAST) begin
            shreg_d   = {bit_val, shreg[7:1]};
            bit_cnt_d = bit_cnt + 4'd1;
            os_cnt_d  = '0;
            if (bit_cnt == 4'd7) state_d = ST_STOP;
          end else begin
            os_cnt_d = os_cnt + OS_ONE;
          end
        end
        ST_STOP: begin
          if (os_cnt == OS_LAST) begin
            state_d  = ST_IDLE;
            os_cnt_d = '0;
            if (bit_val) commit = 1'b1;
            else         ferr_d = 1'b1;
          end else begin
            os_cnt_d = os_cnt + OS_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A same-cycle ack frees the holding register for the new byte.
    if (commit) begin
      if (!valid_q || bus.rx_ack) begin
        data_d  = shreg;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // FSM state register and datapath/status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_d;
      os_cnt  <= os_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule
